// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's control, instruction-memory and decode-side signals.
// The master modport is the fetch stage itself; the slave side is its environment.
interface fetch_stage_if;
  logic [15:0] newPC;
  logic        redirect;
  logic        id_stall;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        imem_done;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_inst;
  logic [15:0] if_pc2;
  logic        halted;

  modport master (
    input  newPC, redirect, id_stall, imem_done, imem_rdata,
    output imem_rd, imem_addr, if_valid, if_inst, if_pc2, halted
  );

  modport slave (
    output newPC, redirect, id_stall, imem_done, imem_rdata,
    input  imem_rd, imem_addr, if_valid, if_inst, if_pc2, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory read, a one-entry skid buffer
// behind the decode-facing output register, redirect squashing and HALT detection.
module fetch_stage (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {FETCH, DRAIN, SKID, HALT} state_e;

  localparam logic [15:0] NOP = 16'h0800;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] target_q, target_d;
  logic [15:0] skidInst_q, skidInst_d;
  logic [15:0] skidPc2_q, skidPc2_d;
  logic        valid_q, valid_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] pc2_q, pc2_d;

  logic        outFree;
  logic [15:0] pcPlus2;

  assign outFree = !valid_q || !bus.id_stall;
  assign pcPlus2 = pc_q + 16'd2;

  // DRAIN keeps pc untouched, so pc_q is also the address of the abandoned request.
  assign bus.imem_rd   = (state_q == FETCH) || (state_q == DRAIN);
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = valid_q;
  assign bus.if_inst   = inst_q;
  assign bus.if_pc2    = pc2_q;
  assign bus.halted    = (state_q == HALT);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    skidInst_d = skidInst_q;
    skidPc2_d  = skidPc2_q;
    valid_d    = outFree ? 1'b0 : valid_q;
    inst_d     = inst_q;
    pc2_d      = pc2_q;

    if (bus.redirect) begin
      valid_d = 1'b0;
      inst_d  = NOP;
      case (state_q)
        FETCH: begin
          if (bus.imem_done) begin
            pc_d = bus.newPC;
          end else begin
            target_d = bus.newPC;
            state_d  = DRAIN;
          end
        end
        DRAIN: begin
          if (bus.imem_done) begin
            pc_d    = bus.newPC;
            state_d = FETCH;
          end else begin
            target_d = bus.newPC;
          end
        end
        default: begin
          pc_d    = bus.newPC;
          state_d = FETCH;
        end
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.imem_done) begin
            pc_d = pcPlus2;
            if (outFree) begin
              valid_d = 1'b1;
              inst_d  = bus.imem_rdata;
              pc2_d   = pcPlus2;
              state_d = (bus.imem_rdata[15:11] == 5'b00000) ? HALT : FETCH;
            end else begin
              skidInst_d = bus.imem_rdata;
              skidPc2_d  = pcPlus2;
              state_d    = SKID;
            end
          end
        end
        DRAIN: begin
          if (bus.imem_done) begin
            pc_d    = target_q;
            state_d = FETCH;
          end
        end
        SKID: begin
          if (outFree) begin
            valid_d = 1'b1;
            inst_d  = skidInst_q;
            pc2_d   = skidPc2_q;
            state_d = (skidInst_q[15:11] == 5'b00000) ? HALT : FETCH;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= 16'h0000;
      target_q   <= 16'h0000;
      skidInst_q <= NOP;
      skidPc2_q  <= 16'h0000;
      valid_q    <= 1'b0;
      inst_q     <= NOP;
      pc2_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      skidInst_q <= skidInst_d;
      skidPc2_q  <= skidPc2_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      pc2_q      <= pc2_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scenario bench for fetch_stage: the bench acts as instruction memory and decode,
// queues each word it expects to see delivered and compares it when it appears.
module tb_fetch_stage;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc2;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  exp_t sb[$];
  exp_t e;

  fetch_stage_if bus();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change right after a falling edge; outputs are sampled at the next one.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleInputs();
    bus.newPC      = 16'h0000;
    bus.redirect   = 1'b0;
    bus.id_stall   = 1'b0;
    bus.imem_done  = 1'b0;
    bus.imem_rdata = 16'h0000;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    idleInputs();
    rst = 1'b1;
    tick();
    vectors++;
    if (bus.if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", bus.if_valid); end
    vectors++;
    if (bus.if_inst !== 16'h0800) begin miscompares++; $display("[TB] FAIL reset_inst got %h want 0800", bus.if_inst); end
    vectors++;
    if (bus.if_pc2 !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_pc2 got %h want 0000", bus.if_pc2); end
    vectors++;
    if (bus.halted !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_halted got %b want 0", bus.halted); end
    vectors++;
    if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0000) begin
      miscompares++; $display("[TB] FAIL reset_req got rd=%b addr=%h want rd=1 addr=0000", bus.imem_rd, bus.imem_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [2];
    words[0] = 16'h4001;
    words[1] = 16'h4002;
    doReset();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (bus.imem_addr !== 16'(2 * i)) begin miscompares++; $display("[TB] FAIL b2b_addr%0d got %h want %h", i, bus.imem_addr, 16'(2 * i)); end
      bus.imem_done  = 1'b1;
      bus.imem_rdata = words[i];
      sb.push_back('{inst: words[i], pc2: 16'(2 * i + 2)});
      tick();
      e = sb.pop_front();
      vectors++;
      if (bus.if_valid !== 1'b1 || bus.if_inst !== e.inst || bus.if_pc2 !== e.pc2) begin
        miscompares++; $display("[TB] FAIL b2b_out%0d got v=%b %h/%h want v=1 %h/%h", i, bus.if_valid, bus.if_inst, bus.if_pc2, e.inst, e.pc2);
      end
    end
    vectors++;
    if (bus.imem_addr !== 16'h0004) begin miscompares++; $display("[TB] FAIL b2b_addr2 got %h want 0004", bus.imem_addr); end
    bus.imem_done = 1'b0;
    tick();
    vectors++;
    if (bus.if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_consumed got %b want 0", bus.if_valid); end
  endtask

  task automatic test_stall_skid();
    doReset();
    bus.imem_done  = 1'b1;
    bus.imem_rdata = 16'h4010;
    sb.push_back('{inst: 16'h4010, pc2: 16'h0002});
    tick();
    bus.id_stall   = 1'b1;
    bus.imem_rdata = 16'h4012;
    sb.push_back('{inst: 16'h4012, pc2: 16'h0004});
    tick();
    bus.imem_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = sb[0];
      vectors++;
      if (bus.if_valid !== 1'b1 || bus.if_inst !== e.inst || bus.if_pc2 !== e.pc2) begin
        miscompares++; $display("[TB] FAIL stall_hold%0d got v=%b %h/%h want v=1 %h/%h", i, bus.if_valid, bus.if_inst, bus.if_pc2, e.inst, e.pc2);
      end
      vectors++;
      if (bus.imem_rd !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_rd%0d got %b want 0", i, bus.imem_rd); end
      if (i == 0) tick();
    end
    bus.id_stall = 1'b0;
    void'(sb.pop_front());
    tick();
    e = sb.pop_front();
    vectors++;
    if (bus.if_valid !== 1'b1 || bus.if_inst !== e.inst || bus.if_pc2 !== e.pc2) begin
      miscompares++; $display("[TB] FAIL skid_out got v=%b %h/%h want v=1 %h/%h", bus.if_valid, bus.if_inst, bus.if_pc2, e.inst, e.pc2);
    end
    vectors++;
    if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0004) begin
      miscompares++; $display("[TB] FAIL skid_resume got rd=%b addr=%h want rd=1 addr=0004", bus.imem_rd, bus.imem_addr);
    end
  endtask

  task automatic test_redirect_drain();
    doReset();
    bus.redirect = 1'b1;
    bus.newPC    = 16'h0100;
    tick();
    bus.redirect = 1'b0;
    bus.newPC    = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0000 || bus.if_valid !== 1'b0) begin
        miscompares++; $display("[TB] FAIL drain_hold%0d got rd=%b addr=%h v=%b want rd=1 addr=0000 v=0", i, bus.imem_rd, bus.imem_addr, bus.if_valid);
      end
      if (i == 0) tick();
    end
    bus.imem_done  = 1'b1;
    bus.imem_rdata = 16'h4444;
    tick();
    vectors++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 16'h0100) begin
      miscompares++; $display("[TB] FAIL drain_discard got v=%b addr=%h want v=0 addr=0100", bus.if_valid, bus.imem_addr);
    end
    bus.imem_rdata = 16'h4100;
    sb.push_back('{inst: 16'h4100, pc2: 16'h0102});
    tick();
    bus.imem_done = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (bus.if_valid !== 1'b1 || bus.if_inst !== e.inst || bus.if_pc2 !== e.pc2) begin
      miscompares++; $display("[TB] FAIL drain_target got v=%b %h/%h want v=1 %h/%h", bus.if_valid, bus.if_inst, bus.if_pc2, e.inst, e.pc2);
    end
  endtask

  task automatic test_halt();
    doReset();
    bus.imem_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.imem_rdata = (i == 3) ? 16'h0000 : 16'(16'h4001 + i);
      sb.push_back('{inst: bus.imem_rdata, pc2: 16'(2 * i + 2)});
      tick();
      e = sb.pop_front();
      vectors++;
      if (bus.if_valid !== 1'b1 || bus.if_inst !== e.inst || bus.if_pc2 !== e.pc2) begin
        miscompares++; $display("[TB] FAIL halt_word%0d got v=%b %h/%h want v=1 %h/%h", i, bus.if_valid, bus.if_inst, bus.if_pc2, e.inst, e.pc2);
      end
    end
    bus.imem_done = 1'b0;
    vectors++;
    if (bus.halted !== 1'b1 || bus.imem_rd !== 1'b0) begin
      miscompares++; $display("[TB] FAIL halt_state got halted=%b rd=%b want halted=1 rd=0", bus.halted, bus.imem_rd);
    end
    tick();
    vectors++;
    if (bus.halted !== 1'b1 || bus.if_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL halt_hold got halted=%b v=%b want halted=1 v=0", bus.halted, bus.if_valid);
    end
    bus.redirect = 1'b1;
    bus.newPC    = 16'h0020;
    tick();
    bus.redirect = 1'b0;
    vectors++;
    if (bus.halted !== 1'b0 || bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0020 || bus.if_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL halt_exit got halted=%b rd=%b addr=%h v=%b want 0 1 0020 0", bus.halted, bus.imem_rd, bus.imem_addr, bus.if_valid);
    end
  endtask

  task automatic test_wrap();
    bus.imem_done  = 1'b1;
    bus.imem_rdata = 16'h4555;
    bus.redirect   = 1'b1;
    bus.newPC      = 16'hFFFE;
    tick();
    bus.redirect = 1'b0;
    vectors++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 16'hFFFE) begin
      miscompares++; $display("[TB] FAIL wrap_redirect got v=%b addr=%h want v=0 addr=FFFE", bus.if_valid, bus.imem_addr);
    end
    bus.imem_rdata = 16'h4777;
    sb.push_back('{inst: 16'h4777, pc2: 16'h0000});
    tick();
    bus.imem_done = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (bus.if_valid !== 1'b1 || bus.if_inst !== e.inst || bus.if_pc2 !== e.pc2) begin
      miscompares++; $display("[TB] FAIL wrap_out got v=%b %h/%h want v=1 %h/%h", bus.if_valid, bus.if_inst, bus.if_pc2, e.inst, e.pc2);
    end
    vectors++;
    if (bus.imem_addr !== 16'h0000) begin miscompares++; $display("[TB] FAIL wrap_addr got %h want 0000", bus.imem_addr); end
  endtask

  task automatic test_reset_mid_drain();
    doReset();
    bus.imem_done  = 1'b1;
    bus.imem_rdata = 16'h4001;
    tick();
    bus.imem_done = 1'b0;
    bus.redirect  = 1'b1;
    bus.newPC     = 16'h0300;
    tick();
    bus.redirect = 1'b0;
    vectors++;
    if (bus.imem_addr !== 16'h0002 || bus.if_pc2 !== 16'h0002 || bus.if_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL pre_rst_drain got addr=%h pc2=%h v=%b want 0002 0002 0", bus.imem_addr, bus.if_pc2, bus.if_valid);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0000 || bus.if_pc2 !== 16'h0000 ||
        bus.if_inst !== 16'h0800 || bus.if_valid !== 1'b0 || bus.halted !== 1'b0) begin
      miscompares++; $display("[TB] FAIL async_rst got rd=%b addr=%h pc2=%h inst=%h v=%b h=%b", bus.imem_rd, bus.imem_addr, bus.if_pc2, bus.if_inst, bus.if_valid, bus.halted);
    end
    @(negedge clk);
    rst            = 1'b0;
    bus.imem_done  = 1'b1;
    bus.imem_rdata = 16'h4999;
    sb.push_back('{inst: 16'h4999, pc2: 16'h0002});
    tick();
    bus.imem_done = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (bus.if_valid !== 1'b1 || bus.if_inst !== e.inst || bus.if_pc2 !== e.pc2) begin
      miscompares++; $display("[TB] FAIL post_rst_fetch got v=%b %h/%h want v=1 %h/%h", bus.if_valid, bus.if_inst, bus.if_pc2, e.inst, e.pc2);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    idleInputs();
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_stall_skid();
    test_redirect_drain();
    test_halt();
    test_wrap();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
